// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/ctrl_imm_dec.sv
// Immediate-format decode: purely combinational from the opcode.
module ctrl_imm_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] i_op,
  output logic [1:0] o_imm_src
);

  always_comb begin
    o_imm_src = IMM_I;
    case (i_op)
      OP_STORE:  o_imm_src = IMM_S;
      OP_BRANCH: o_imm_src = IMM_B;
      OP_JAL:    o_imm_src = IMM_J;
      default:   o_imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I main control: Moore FSM, datapath select decode,
// sticky illegal-opcode flag and retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE   = 1'b1,
  parameter bit          SUPPORT_BNE     = 1'b1,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       imm_src,
  output logic             reg_write,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_e           r_state;
  state_e           w_next_state;
  logic             w_rdy;
  logic             w_br_take;
  logic             w_retire;
  logic             w_pc_write;
  logic             w_mem_write;
  logic             w_ir_write;
  logic             w_reg_write;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instret;
  logic             w_unused_funct3;

  assign w_rdy           = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign w_br_take       = zero ^ (SUPPORT_BNE & funct3[0]);
  assign w_unused_funct3 = ^funct3[2:1];

  ctrl_imm_dec u_imm_dec (
    .i_op      (op),
    .o_imm_src (imm_src)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  // Next state, select decode and ungated enables.
  always_comb begin
    w_next_state = r_state;
    adr_src      = 1'b0;
    result_src   = RES_ALUOUT;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RD2;
    alu_op       = ALUOP_ADD;
    w_pc_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      S_FETCH: begin
        result_src = RES_ALURESULT;
        alu_src_b  = SRCB_FOUR;
        w_ir_write = w_rdy;
        w_pc_write = w_rdy;
        if (w_rdy) w_next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
          OP_R:              w_next_state = S_EXECR;
          OP_I:              w_next_state = S_EXECI;
          OP_BRANCH:         w_next_state = S_BRANCH;
          OP_JAL:            w_next_state = S_JAL;
          default: begin
            if (TRAP_ON_ILLEGAL) w_next_state = S_TRAP;
            else                 w_next_state = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        if (op == OP_LOAD) w_next_state = S_MEMREAD;
        else               w_next_state = S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (w_rdy) w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src   = RES_DATA;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        w_mem_write = 1'b1;
        if (w_rdy) begin
          w_retire     = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a    = SRCA_RD1;
        alu_op       = ALUOP_FUNCT;
        w_next_state = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a    = SRCA_RD1;
        alu_src_b    = SRCB_IMM;
        alu_op       = ALUOP_FUNCT;
        w_next_state = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = SRCA_RD1;
        alu_op       = ALUOP_SUB;
        w_pc_write   = w_br_take;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      // Link address PC+4 is written back through ALUWB.
      S_JAL: begin
        alu_src_a    = SRCA_OLDPC;
        alu_src_b    = SRCB_FOUR;
        w_pc_write   = 1'b1;
        w_next_state = S_ALUWB;
      end
      S_TRAP:  w_next_state = S_TRAP;
      default: w_next_state = S_FETCH;
    endcase
  end

  // Enables are suppressed for the whole time reset is held.
  assign pc_write  = w_pc_write  & ~reset;
  assign mem_write = w_mem_write & ~reset;
  assign ir_write  = w_ir_write  & ~reset;
  assign reg_write = w_reg_write & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instret <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (w_retire)                r_instret <= r_instret + CNT_W'(1);
      if (w_next_state == S_TRAP)  r_illegal <= 1'b1;
    end
  end

  assign instret = r_instret;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: default instance plus a variant with
// no handshake, beq-only branches, illegal-as-nop and a 4-bit counter.
module tb_multicycle_ctrl;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BAD    = 7'b1111111;

  // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_op, reg_write}
  localparam logic [12:0] V_FR    = 13'b1_0_0_1_10_00_10_00_0;
  localparam logic [12:0] V_FS    = 13'b0_0_0_0_10_00_10_00_0;
  localparam logic [12:0] V_DEC   = 13'b0_0_0_0_00_01_01_00_0;
  localparam logic [12:0] V_MADR  = 13'b0_0_0_0_00_10_01_00_0;
  localparam logic [12:0] V_MRD   = 13'b0_1_0_0_00_00_00_00_0;
  localparam logic [12:0] V_MWB   = 13'b0_0_0_0_01_00_00_00_1;
  localparam logic [12:0] V_MWR   = 13'b0_1_1_0_00_00_00_00_0;
  localparam logic [12:0] V_EXR   = 13'b0_0_0_0_00_10_00_10_0;
  localparam logic [12:0] V_EXI   = 13'b0_0_0_0_00_10_01_10_0;
  localparam logic [12:0] V_AWB   = 13'b0_0_0_0_00_00_00_00_1;
  localparam logic [12:0] V_BR_T  = 13'b1_0_0_0_00_10_00_01_0;
  localparam logic [12:0] V_BR_N  = 13'b0_0_0_0_00_10_00_01_0;
  localparam logic [12:0] V_JAL   = 13'b1_0_0_0_00_01_10_00_0;
  localparam logic [12:0] V_TRAP  = 13'b0_0_0_0_00_00_00_00_0;

  logic        clk;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        zero;
  logic        mem_ready;

  logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic [31:0] instret;

  logic        pc_write_b, adr_src_b, mem_write_b, ir_write_b, reg_write_b, illegal_b;
  logic [1:0]  result_src_b, alu_src_a_b, alu_src_b_b, alu_op_b, imm_src_b;
  logic [3:0]  instret_b;

  logic [12:0] obs, obs_b;
  int          n_checks;
  int          n_errors;

  assign obs   = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                  alu_src_b, alu_op, reg_write};
  assign obs_b = {pc_write_b, adr_src_b, mem_write_b, ir_write_b, result_src_b, alu_src_a_b,
                  alu_src_b_b, alu_op_b, reg_write_b};

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_src(imm_src), .reg_write(reg_write), .illegal(illegal), .instret(instret)
  );

  multicycle_ctrl #(
    .MEM_HANDSHAKE(1'b0), .SUPPORT_BNE(1'b0), .TRAP_ON_ILLEGAL(1'b0), .CNT_W(4)
  ) dut_b (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write_b), .adr_src(adr_src_b), .mem_write(mem_write_b), .ir_write(ir_write_b),
    .result_src(result_src_b), .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b),
    .alu_op(alu_op_b), .imm_src(imm_src_b), .reg_write(reg_write_b), .illegal(illegal_b),
    .instret(instret_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] ops [7];
    logic [1:0] ims [7];
    ops = '{OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_I, OPC_R, OPC_BAD};
    ims = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};
    @(negedge clk);
    mem_ready = 1'b1; op = OPC_R;
    #1;
    n_checks++; if (obs !== V_FS) begin n_errors++; $display("FAIL reset_ctrl: got %b expected %b", obs, V_FS); end
    n_checks++; if (obs_b !== V_FS) begin n_errors++; $display("FAIL reset_ctrl_b: got %b expected %b", obs_b, V_FS); end
    n_checks++; if (instret !== 32'd0) begin n_errors++; $display("FAIL reset_instret: got %0d expected 0", instret); end
    n_checks++; if (instret_b !== 4'd0) begin n_errors++; $display("FAIL reset_instret_b: got %0d expected 0", instret_b); end
    n_checks++; if (illegal !== 1'b0) begin n_errors++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
    for (int i = 0; i < 7; i++) begin
      op = ops[i];
      #1;
      n_checks++; if (imm_src !== ims[i]) begin n_errors++; $display("FAIL imm_src op=%b: got %b expected %b", ops[i], imm_src, ims[i]); end
      n_checks++; if (imm_src_b !== ims[i]) begin n_errors++; $display("FAIL imm_src_b op=%b: got %b expected %b", ops[i], imm_src_b, ims[i]); end
    end
    @(negedge clk);
    reset = 1'b0; op = OPC_R;
    #1;
    n_checks++; if (obs !== V_FR) begin n_errors++; $display("FAIL post_reset_fetch: got %b expected %b", obs, V_FR); end
  endtask

  task automatic test_lw();
    logic [12:0] ev [6];
    int          cnt [6];
    ev  = '{V_FR, V_DEC, V_MADR, V_MRD, V_MWB, V_FR};
    cnt = '{0, 0, 0, 0, 0, 1};
    do_reset();
    op = OPC_LOAD; funct3 = 3'b010; mem_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++; if (obs !== ev[c]) begin n_errors++; $display("FAIL lw_cycle%0d: got %b expected %b", c, obs, ev[c]); end
      n_checks++; if (obs_b !== ev[c]) begin n_errors++; $display("FAIL lw_b_cycle%0d: got %b expected %b", c, obs_b, ev[c]); end
      n_checks++; if (instret !== 32'(cnt[c])) begin n_errors++; $display("FAIL lw_instret%0d: got %0d expected %0d", c, instret, cnt[c]); end
      n_checks++; if (instret_b !== 4'(cnt[c])) begin n_errors++; $display("FAIL lw_instret_b%0d: got %0d expected %0d", c, instret_b, cnt[c]); end
      @(negedge clk);
    end
  endtask

  task automatic test_sw_stall();
    logic [12:0] ev  [9];
    logic        rdy [9];
    int          cnt [9];
    ev  = '{V_FR, V_DEC, V_MADR, V_MWR, V_MWR, V_MWR, V_MWR, V_FS, V_FS};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    cnt = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
    do_reset();
    op = OPC_STORE; funct3 = 3'b010;
    for (int c = 0; c < 9; c++) begin
      mem_ready = rdy[c];
      #1;
      n_checks++; if (obs !== ev[c]) begin n_errors++; $display("FAIL sw_cycle%0d: got %b expected %b", c, obs, ev[c]); end
      n_checks++; if (instret !== 32'(cnt[c])) begin n_errors++; $display("FAIL sw_instret%0d: got %0d expected %0d", c, instret, cnt[c]); end
      if (c == 0) begin
        n_checks++; if (imm_src !== 2'b01) begin n_errors++; $display("FAIL sw_imm_src: got %b expected 01", imm_src); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_itype();
    logic [12:0] ev [5];
    int          cnt [5];
    ev  = '{V_FR, V_DEC, V_EXI, V_AWB, V_FR};
    cnt = '{0, 0, 0, 0, 1};
    do_reset();
    op = OPC_I; funct3 = 3'b000; mem_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (obs !== ev[c]) begin n_errors++; $display("FAIL itype_cycle%0d: got %b expected %b", c, obs, ev[c]); end
      n_checks++; if (obs_b !== ev[c]) begin n_errors++; $display("FAIL itype_b_cycle%0d: got %b expected %b", c, obs_b, ev[c]); end
      n_checks++; if (instret !== 32'(cnt[c])) begin n_errors++; $display("FAIL itype_instret%0d: got %0d expected %0d", c, instret, cnt[c]); end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [2:0]  f3 [4];
    logic        zz [4];
    logic        ta [4];
    logic        tb [4];
    logic [12:0] ea, eb;
    f3 = '{3'b001, 3'b001, 3'b000, 3'b000};
    zz = '{1'b0, 1'b1, 1'b1, 1'b0};
    ta = '{1'b1, 1'b0, 1'b1, 1'b0};
    tb = '{1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    op = OPC_BRANCH; mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      funct3 = f3[k]; zero = zz[k];
      #1;
      n_checks++; if (obs !== V_FR) begin n_errors++; $display("FAIL br%0d_fetch: got %b expected %b", k, obs, V_FR); end
      n_checks++; if (instret !== 32'(k)) begin n_errors++; $display("FAIL br%0d_instret: got %0d expected %0d", k, instret, k); end
      n_checks++; if (instret_b !== 4'(k)) begin n_errors++; $display("FAIL br%0d_instret_b: got %0d expected %0d", k, instret_b, k); end
      @(negedge clk);
      @(negedge clk);
      #1;
      ea = ta[k] ? V_BR_T : V_BR_N;
      eb = tb[k] ? V_BR_T : V_BR_N;
      n_checks++; if (obs !== ea) begin n_errors++; $display("FAIL br%0d_bne: got %b expected %b", k, obs, ea); end
      n_checks++; if (obs_b !== eb) begin n_errors++; $display("FAIL br%0d_beq_only: got %b expected %b", k, obs_b, eb); end
      n_checks++; if (imm_src !== 2'b10) begin n_errors++; $display("FAIL br%0d_imm_src: got %b expected 10", k, imm_src); end
      @(negedge clk);
    end
  endtask

  task automatic test_jal();
    logic [12:0] ev [5];
    int          cnt [5];
    ev  = '{V_FR, V_DEC, V_JAL, V_AWB, V_FR};
    cnt = '{0, 0, 0, 0, 1};
    do_reset();
    op = OPC_JAL; funct3 = 3'b000; mem_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (obs !== ev[c]) begin n_errors++; $display("FAIL jal_cycle%0d: got %b expected %b", c, obs, ev[c]); end
      n_checks++; if (obs_b !== ev[c]) begin n_errors++; $display("FAIL jal_b_cycle%0d: got %b expected %b", c, obs_b, ev[c]); end
      n_checks++; if (instret !== 32'(cnt[c])) begin n_errors++; $display("FAIL jal_instret%0d: got %0d expected %0d", c, instret, cnt[c]); end
      @(negedge clk);
    end
    #1;
    n_checks++; if (imm_src !== 2'b11) begin n_errors++; $display("FAIL jal_imm_src: got %b expected 11", imm_src); end
  endtask

  task automatic test_trap();
    do_reset();
    op = OPC_R; mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    op = OPC_BAD;
    #1;
    n_checks++; if (obs !== V_FR) begin n_errors++; $display("FAIL trap_fetch: got %b expected %b", obs, V_FR); end
    @(negedge clk);
    #1;
    n_checks++; if (obs !== V_DEC) begin n_errors++; $display("FAIL trap_decode: got %b expected %b", obs, V_DEC); end
    n_checks++; if (illegal !== 1'b0) begin n_errors++; $display("FAIL trap_pre_illegal: got %b expected 0", illegal); end
    @(negedge clk);
    #1;
    n_checks++; if (obs_b !== V_FR) begin n_errors++; $display("FAIL nop_b_fetch: got %b expected %b", obs_b, V_FR); end
    n_checks++; if (illegal_b !== 1'b0) begin n_errors++; $display("FAIL nop_b_illegal: got %b expected 0", illegal_b); end
    n_checks++; if (instret_b !== 4'd1) begin n_errors++; $display("FAIL nop_b_instret: got %0d expected 1", instret_b); end
    for (int c = 0; c < 12; c++) begin
      zero = c[0];
      #1;
      n_checks++; if (obs !== V_TRAP) begin n_errors++; $display("FAIL trap_cycle%0d: got %b expected %b", c, obs, V_TRAP); end
      n_checks++; if (illegal !== 1'b1) begin n_errors++; $display("FAIL trap_illegal%0d: got %b expected 1", c, illegal); end
      n_checks++; if (instret !== 32'd1) begin n_errors++; $display("FAIL trap_instret%0d: got %0d expected 1", c, instret); end
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    n_checks++; if (obs !== V_FS) begin n_errors++; $display("FAIL trap_reset_ctrl: got %b expected %b", obs, V_FS); end
    n_checks++; if (illegal !== 1'b0) begin n_errors++; $display("FAIL trap_reset_illegal: got %b expected 0", illegal); end
    n_checks++; if (instret !== 32'd0) begin n_errors++; $display("FAIL trap_reset_instret: got %0d expected 0", instret); end
    @(negedge clk);
    reset = 1'b0; op = OPC_R;
    #1;
    n_checks++; if (obs !== V_FR) begin n_errors++; $display("FAIL trap_exit_fetch: got %b expected %b", obs, V_FR); end
  endtask

  task automatic test_back_to_back();
    logic [12:0] ev [4];
    ev = '{V_FR, V_DEC, V_EXR, V_AWB};
    do_reset();
    op = OPC_R; funct3 = 3'b000; mem_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      for (int c = 0; c < 4; c++) begin
        #1;
        n_checks++; if (obs !== ev[c]) begin n_errors++; $display("FAIL r%0d_cycle%0d: got %b expected %b", k, c, obs, ev[c]); end
        if (c == 0) begin
          n_checks++; if (instret !== 32'(k)) begin n_errors++; $display("FAIL r%0d_instret: got %0d expected %0d", k, instret, k); end
          n_checks++; if (instret_b !== 4'(k)) begin n_errors++; $display("FAIL r%0d_instret_b: got %0d expected %0d", k, instret_b, k % 16); end
        end
        @(negedge clk);
      end
    end
    #1;
    n_checks++; if (instret !== 32'd17) begin n_errors++; $display("FAIL b2b_instret: got %0d expected 17", instret); end
    n_checks++; if (instret_b !== 4'd1) begin n_errors++; $display("FAIL b2b_wrap_instret_b: got %0d expected 1", instret_b); end
  endtask

  initial begin
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b1;
    n_checks = 0; n_errors = 0;
    test_reset();
    test_lw();
    test_sw_stall();
    test_itype();
    test_branch();
    test_jal();
    test_trap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
